// File: rtl/lzy_guess_ctrl.sv
// Number-guessing round controller: edge-detected START/TRY, comparator decode, hints and win/lose.
// Optional idle timeout in PLAY is enabled by defining LZY_GUESS_TIMEOUT_EN.
module lzy_guess_ctrl #(
  parameter int MAX_TRIES   = 6,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       try,
  input  logic       qg,
  input  logic       qe,
  input  logic       qs,
  output logic       hint_hi,
  output logic       hint_lo,
  output logic       win,
  output logic       lose,
  output logic [3:0] tries,
  output logic       busy,
  output logic       err
);

  typedef enum logic [1:0] {IDLE, PLAY, WON, LOST} state_t;

  localparam logic [3:0] MAX_T = 4'(MAX_TRIES);

  if (MAX_TRIES < 1 || MAX_TRIES > 15 || TIMEOUT_CYC < 1 || TIMEOUT_CYC > 255) begin : g_bad_param
    $error("lzy_guess_ctrl: parameter out of range");
  end

  state_t     state_q, state_d;
  logic       start_d_q, try_d_q, arm_q;
  logic [3:0] tries_q, tries_d, tries_inc;
  logic       hint_hi_q, hint_hi_d, hint_lo_q, hint_lo_d, err_q, err_d;
  logic       start_rise, try_rise, legal;

  // arm_q masks the first edge after reset so a level held across release is not a rise
  assign start_rise = arm_q & start & ~start_d_q;
  assign try_rise   = arm_q & try & ~try_d_q;
  assign legal      = (qg ^ qe ^ qs) & ~(qg & qe & qs);
  assign tries_inc  = tries_q + 4'd1;

`ifdef LZY_GUESS_TIMEOUT_EN
  localparam logic [7:0] TMO = 8'(TIMEOUT_CYC);
  logic [7:0] tmo_q, tmo_d, tmo_inc;
  assign tmo_inc = tmo_q + 8'd1;
`endif

  always_comb begin
    state_d   = state_q;
    tries_d   = tries_q;
    hint_hi_d = hint_hi_q;
    hint_lo_d = hint_lo_q;
    err_d     = err_q;
`ifdef LZY_GUESS_TIMEOUT_EN
    tmo_d     = tmo_q;
`endif
    if (start_rise) begin
      state_d   = PLAY;
      tries_d   = 4'd0;
      hint_hi_d = 1'b0;
      hint_lo_d = 1'b0;
      err_d     = 1'b0;
`ifdef LZY_GUESS_TIMEOUT_EN
      tmo_d     = 8'd0;
`endif
    end else if (state_q == PLAY) begin
`ifdef LZY_GUESS_TIMEOUT_EN
      tmo_d = tmo_inc;
`endif
      if (try_rise && !legal) begin
        err_d = 1'b1;
      end else if (try_rise) begin
        tries_d = tries_inc;
`ifdef LZY_GUESS_TIMEOUT_EN
        tmo_d   = 8'd0;
`endif
        if (qe) begin
          hint_hi_d = 1'b0;
          hint_lo_d = 1'b0;
          state_d   = WON;
        end else begin
          hint_hi_d = qg;
          hint_lo_d = qs;
          if (tries_inc == MAX_T) state_d = LOST;
        end
      end
`ifdef LZY_GUESS_TIMEOUT_EN
      // a legal try restarts the idle window, so only otherwise can the timeout fire
      if (!(try_rise && legal) && tmo_inc == TMO) state_d = LOST;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      start_d_q <= 1'b0;
      try_d_q   <= 1'b0;
      arm_q     <= 1'b0;
      tries_q   <= 4'd0;
      hint_hi_q <= 1'b0;
      hint_lo_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      start_d_q <= start;
      try_d_q   <= try;
      arm_q     <= 1'b1;
      tries_q   <= tries_d;
      hint_hi_q <= hint_hi_d;
      hint_lo_q <= hint_lo_d;
      err_q     <= err_d;
    end
  end

`ifdef LZY_GUESS_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) tmo_q <= 8'd0;
    else     tmo_q <= tmo_d;
  end
`endif

  assign hint_hi = hint_hi_q;
  assign hint_lo = hint_lo_q;
  assign tries   = tries_q;
  assign err     = err_q;
  assign win     = (state_q == WON);
  assign lose    = (state_q == LOST);
  assign busy    = (state_q == PLAY);

endmodule

// File: tb/tb_lzy_guess_ctrl.sv
// Self-checking bench for lzy_guess_ctrl: directed scenarios plus random traffic against a round-level model.
module tb_lzy_guess_ctrl;
  localparam int MAXT = 6;
  localparam int TMO  = 20;

  logic       clk = 1'b0, rst = 1'b1;
  logic       start = 1'b0, try = 1'b0, qg = 1'b0, qe = 1'b0, qs = 1'b0;
  logic       hint_hi, hint_lo, win, lose, busy, err;
  logic [3:0] tries;

  int errorCount = 0;
  int checkCount = 0;

  // round-level model of the game
  bit inRound, roundWon, roundLost, hintHi, hintLo, errFlag;
  int triesUsed, idleCycles;
  bit prevStart, prevTry, armed;

  lzy_guess_ctrl #(.MAX_TRIES(MAXT), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst(rst), .start(start), .try(try), .qg(qg), .qe(qe), .qs(qs),
    .hint_hi(hint_hi), .hint_lo(hint_lo), .win(win), .lose(lose),
    .tries(tries), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelReset();
    inRound = 0; roundWon = 0; roundLost = 0; hintHi = 0; hintLo = 0; errFlag = 0;
    triesUsed = 0; idleCycles = 0; prevStart = 0; prevTry = 0; armed = 0;
  endtask

  task automatic modelEdge();
    bit sr, tr, legalTry;
    sr = armed && start && !prevStart;
    tr = armed && try && !prevTry;
    prevStart = start; prevTry = try; armed = 1;
    legalTry = (int'(qg) + int'(qe) + int'(qs)) == 1;
    if (sr) begin
      inRound = 1; roundWon = 0; roundLost = 0;
      triesUsed = 0; hintHi = 0; hintLo = 0; errFlag = 0; idleCycles = 0;
    end else if (inRound) begin
      if (tr && !legalTry) errFlag = 1;
      if (tr && legalTry) begin
        triesUsed++;
        idleCycles = 0;
        if (qe) begin
          hintHi = 0; hintLo = 0; inRound = 0; roundWon = 1;
        end else begin
          hintHi = qg; hintLo = qs;
          if (triesUsed == MAXT) begin inRound = 0; roundLost = 1; end
        end
      end else begin
        idleCycles++;
`ifdef LZY_GUESS_TIMEOUT_EN
        if (idleCycles == TMO) begin inRound = 0; roundLost = 1; end
`endif
      end
    end
  endtask

  task automatic compareAll(input string tag);
    checkOutput({tag, "_win"},   8'(win),     8'(roundWon));
    checkOutput({tag, "_lose"},  8'(lose),    8'(roundLost));
    checkOutput({tag, "_busy"},  8'(busy),    8'(inRound));
    checkOutput({tag, "_tries"}, 8'(tries),   8'(triesUsed));
    checkOutput({tag, "_hi"},    8'(hint_hi), 8'(hintHi));
    checkOutput({tag, "_lo"},    8'(hint_lo), 8'(hintLo));
    checkOutput({tag, "_err"},   8'(err),     8'(errFlag));
  endtask

  task automatic applyStimulus(input bit s, input bit t, input bit g, input bit e, input bit l, input string tag);
    start = s; try = t; qg = g; qe = e; qs = l;
    @(posedge clk);
    modelEdge();
    #1;
    compareAll(tag);
  endtask

  task automatic pressTry(input bit g, input bit e, input bit l, input string tag);
    applyStimulus(0, 1, g, e, l, tag);
    applyStimulus(0, 0, 0, 0, 0, tag);
  endtask

  task automatic newRound(input string tag);
    applyStimulus(0, 0, 0, 0, 0, tag);
    applyStimulus(1, 0, 0, 0, 0, tag);
    applyStimulus(0, 0, 0, 0, 0, tag);
  endtask

  task automatic doReset(input string tag);
    rst = 1'b1;
    #1;
    modelReset();
    compareAll({tag, "_async"});
    @(posedge clk);
    #1;
    compareAll({tag, "_held"});
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    modelReset();
    doReset("por");

    newRound("r34_start");
    checkOutput("r34_busy0", 8'(busy), 8'd1);
    pressTry(0, 0, 1, "r34_qs");
    checkOutput("r34_lo", 8'(hint_lo), 8'd1);
    checkOutput("r34_tries1", 8'(tries), 8'd1);
    checkOutput("r34_busy", 8'(busy), 8'd1);
    pressTry(0, 1, 0, "r34_qe");
    checkOutput("r34_win", 8'(win), 8'd1);
    checkOutput("r34_tries2", 8'(tries), 8'd2);
    checkOutput("r34_hints", 8'({hint_hi, hint_lo}), 8'd0);

    newRound("r35_start");
    for (int i = 0; i < MAXT; i++) begin
      checkOutput("r35_notlost", 8'(lose), 8'd0);
      pressTry(1, 0, 0, "r35_qg");
    end
    checkOutput("r35_hi", 8'(hint_hi), 8'd1);
    checkOutput("r35_tries6", 8'(tries), 8'(MAXT));
    checkOutput("r35_lose", 8'(lose), 8'd1);
    pressTry(1, 0, 0, "r35_extra");
    checkOutput("r35_hold", 8'(tries), 8'(MAXT));

    newRound("r36_start");
    pressTry(0, 0, 1, "r36_ok");
    pressTry(1, 0, 1, "r36_bad");
    checkOutput("r36_err", 8'(err), 8'd1);
    checkOutput("r36_tries", 8'(tries), 8'd1);
    newRound("r36_restart");
    checkOutput("r36_errclr", 8'(err), 8'd0);
    checkOutput("r36_tries0", 8'(tries), 8'd0);

    applyStimulus(0, 0, 0, 0, 0, "r37_pre");
    applyStimulus(1, 1, 0, 1, 0, "r37_both");
    checkOutput("r37_busy", 8'(busy), 8'd1);
    checkOutput("r37_tries", 8'(tries), 8'd0);
    checkOutput("r37_win", 8'(win), 8'd0);
    applyStimulus(1, 0, 0, 0, 0, "r37_rel");
    for (int i = 0; i < 10; i++) applyStimulus(1, 1, 0, 0, 1, "r37_hold");
    checkOutput("r37_once", 8'(tries), 8'd1);

    newRound("r38_start");
    for (int i = 0; i < 3; i++) pressTry(0, 0, 1, "r38_qs");
    checkOutput("r38_tries3", 8'(tries), 8'd3);
    start = 1'b1;
    #2;
    doReset("r38");
    checkOutput("r38_zero", 8'({hint_hi, hint_lo, win, lose, busy, err, tries}), 8'd0);
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 0, 0, "r38_after");
    checkOutput("r38_idle", 8'(busy), 8'd0);

    newRound("r39_start");
`ifdef LZY_GUESS_TIMEOUT_EN
    for (int i = 0; i < TMO - 2; i++) applyStimulus(0, 0, 0, 0, 0, "r39_wait");
    checkOutput("r39_notyet", 8'(lose), 8'd0);
    applyStimulus(0, 0, 0, 0, 0, "r39_last");
    checkOutput("r39_lose", 8'(lose), 8'd1);
`else
    for (int i = 0; i < 1000; i++) applyStimulus(0, 0, 0, 0, 0, "r39_wait");
    checkOutput("r39_busy", 8'(busy), 8'd1);
`endif

    for (int n = 0; n < 3000; n++) begin
      logic [2:0] code;
      int sel;
      if ($urandom_range(0, 299) == 0) begin
        #2;
        doReset("rnd_rst");
      end
      sel = int'($urandom_range(0, 7));
      case (sel)
        0, 1, 2: code = 3'b100;
        3, 4:    code = 3'b001;
        5:       code = 3'b010;
        6:       code = 3'($urandom);
        default: code = 3'b000;
      endcase
      applyStimulus($urandom_range(0, 24) == 0, $urandom_range(0, 2) == 0,
                    code[2], code[1], code[0], "rnd");
    end

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
